// File: rtl/tdp_ram18k_port_arbiter.sv
// Purpose: two-requester arbiter in front of one port of an 18 Kb true-dual-port RAM, with read-response routing.
// Latency: request registered to the RAM on its acceptance edge; read response READ_LATENCY edges later.
// Backpressure: REQ_READY_n is combinational grant (one winner per cycle); responses have no backpressure.
module tdp_ram18k_port_arbiter #(
    parameter int READ_LATENCY   = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID_0,
    input  logic        REQ_VALID_1,
    output logic        REQ_READY_0,
    output logic        REQ_READY_1,
    input  logic        REQ_WE_0,
    input  logic        REQ_WE_1,
    input  logic [13:0] REQ_ADDR_0,
    input  logic [13:0] REQ_ADDR_1,
    input  logic [17:0] REQ_WDATA_0,
    input  logic [17:0] REQ_WDATA_1,
    input  logic [1:0]  REQ_BE_0,
    input  logic [1:0]  REQ_BE_1,
    output logic        RSP_VALID_0,
    output logic        RSP_VALID_1,
    output logic [17:0] RSP_DATA,
    output logic        RAM_WEN,
    output logic        RAM_REN,
    output logic [1:0]  RAM_BE,
    output logic [13:0] RAM_ADDR,
    output logic [15:0] RAM_WDATA,
    output logic [1:0]  RAM_WPARITY,
    input  logic [15:0] RAM_RDATA,
    input  logic [1:0]  RAM_RPARITY,
    output logic [15:0] CONFLICT_CNT
);

    generate
        if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_read_latency
            $error("tdp_ram18k_port_arbiter: READ_LATENCY must be 1 or 2");
        end
        if (!(FIXED_PRIORITY == 0 || FIXED_PRIORITY == 1)) begin : g_bad_fixed_priority
            $error("tdp_ram18k_port_arbiter: FIXED_PRIORITY must be 0 or 1");
        end
    endgenerate

    // Grant and selected-request signals
    logic        gnt_vld;
    logic        gnt_id;
    logic        sel_we;
    logic [13:0] sel_addr;
    logic [17:0] sel_wdata;
    logic [1:0]  sel_be;

    // State registers
    logic        ram_wen_q,   ram_wen_d;
    logic        ram_ren_q,   ram_ren_d;
    logic [1:0]  ram_be_q,    ram_be_d;
    logic [13:0] ram_addr_q,  ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic [1:0]  ram_wpar_q,  ram_wpar_d;
    logic        rid_q,       rid_d;      // requester id travelling with the RAM command
    logic        last_q,      last_d;     // most recently granted requester
    logic [15:0] cnt_q,       cnt_d;
    logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0] tag_id_q,  tag_id_d;

    // Pick a winner: a lone requester wins at once; on contention either
    // requester 0 always wins or the one not served last time wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!RESET) begin
            if (REQ_VALID_0 && REQ_VALID_1) begin
                gnt_vld = 1'b1;
                gnt_id  = (FIXED_PRIORITY == 1) ? 1'b0 : ~last_q;
            end else if (REQ_VALID_0) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (REQ_VALID_1) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign REQ_READY_0 = gnt_vld && !gnt_id;
    assign REQ_READY_1 = gnt_vld &&  gnt_id;

    // Route the granted requester's fields toward the RAM command register
    always_comb begin
        sel_we    = REQ_WE_0;
        sel_addr  = REQ_ADDR_0;
        sel_wdata = REQ_WDATA_0;
        sel_be    = REQ_BE_0;
        if (gnt_id) begin
            sel_we    = REQ_WE_1;
            sel_addr  = REQ_ADDR_1;
            sel_wdata = REQ_WDATA_1;
            sel_be    = REQ_BE_1;
        end
    end

    // Next state: RAM command strobes pulse per acceptance, fields hold between
    // acceptances, read tags shift toward the response outputs.
    always_comb begin
        ram_wen_d   = 1'b0;
        ram_ren_d   = 1'b0;
        ram_be_d    = ram_be_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wpar_d  = ram_wpar_q;
        rid_d       = rid_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        tag_vld_d   = tag_vld_q;
        tag_id_d    = tag_id_q;

        if (gnt_vld) begin
            ram_wen_d   = sel_we;
            ram_ren_d   = !sel_we;
            ram_be_d    = sel_be;
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_wdata[15:0];
            ram_wpar_d  = sel_wdata[17:16];
            rid_d       = gnt_id;
            last_d      = gnt_id;
        end

        // The RAM sees the read one edge after acceptance, so the first tag
        // stage is fed from the registered read strobe.
        tag_vld_d[0] = ram_ren_q;
        tag_id_d[0]  = rid_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        if (REQ_VALID_0 && REQ_VALID_1 && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State register; reset drops in-flight tags so stale reads never answer
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ram_wen_q   <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_be_q    <= 2'b00;
            ram_addr_q  <= 14'd0;
            ram_wdata_q <= 16'd0;
            ram_wpar_q  <= 2'b00;
            rid_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 16'd0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
        end else begin
            ram_wen_q   <= ram_wen_d;
            ram_ren_q   <= ram_ren_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wpar_q  <= ram_wpar_d;
            rid_q       <= rid_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign RAM_WEN      = ram_wen_q;
    assign RAM_REN      = ram_ren_q;
    assign RAM_BE       = ram_be_q;
    assign RAM_ADDR     = ram_addr_q;
    assign RAM_WDATA    = ram_wdata_q;
    assign RAM_WPARITY  = ram_wpar_q;
    assign CONFLICT_CNT = cnt_q;

    assign RSP_VALID_0  = !RESET && tag_vld_q[READ_LATENCY-1] && !tag_id_q[READ_LATENCY-1];
    assign RSP_VALID_1  = !RESET && tag_vld_q[READ_LATENCY-1] &&  tag_id_q[READ_LATENCY-1];
    assign RSP_DATA     = {RAM_RPARITY, RAM_RDATA};

endmodule

// File: tb/tb_tdp_ram18k_port_arbiter.sv
// Purpose: scoreboard bench for tdp_ram18k_port_arbiter in three configurations, each with a behavioural write-first RAM.
// Latency: grants checked in the cycle presented; responses checked whenever a RSP_VALID pulse appears.
// Backpressure: requests are re-presented each cycle by the stimulus; responses are always consumed.
module tb_tdp_ram18k_port_arbiter;

    logic CLK;
    logic RESET;

    // Instance 0: READ_LATENCY 1 round-robin; 1: fixed priority; 2: READ_LATENCY 2 round-robin
    logic        v0 [3], v1 [3], we0 [3], we1 [3];
    logic [13:0] a0 [3], a1 [3];
    logic [17:0] wd0 [3], wd1 [3];
    logic [1:0]  be0 [3], be1 [3];
    logic        rdy0 [3], rdy1 [3], rv0 [3], rv1 [3];
    logic [17:0] rdat [3];
    logic        rwen [3], rren [3];
    logic [1:0]  rbe [3], rwp [3], rrp [3];
    logic [13:0] raddr [3];
    logic [15:0] rwd [3], rrd [3];
    logic [15:0] cc [3];

    int checks;
    int failures;

    int          gq [$];   // expected grants: inst*2 + requester
    logic [20:0] rq [$];   // expected responses: {inst, requester, data}

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int RL = (g == 2) ? 2 : 1;
        localparam int FP = (g == 1) ? 1 : 0;
        logic [17:0] mem [0:16383];
        logic [17:0] rd1, rd2;

        tdp_ram18k_port_arbiter #(.READ_LATENCY(RL), .FIXED_PRIORITY(FP)) u_dut (
            .CLK(CLK), .RESET(RESET),
            .REQ_VALID_0(v0[g]), .REQ_VALID_1(v1[g]),
            .REQ_READY_0(rdy0[g]), .REQ_READY_1(rdy1[g]),
            .REQ_WE_0(we0[g]), .REQ_WE_1(we1[g]),
            .REQ_ADDR_0(a0[g]), .REQ_ADDR_1(a1[g]),
            .REQ_WDATA_0(wd0[g]), .REQ_WDATA_1(wd1[g]),
            .REQ_BE_0(be0[g]), .REQ_BE_1(be1[g]),
            .RSP_VALID_0(rv0[g]), .RSP_VALID_1(rv1[g]), .RSP_DATA(rdat[g]),
            .RAM_WEN(rwen[g]), .RAM_REN(rren[g]), .RAM_BE(rbe[g]),
            .RAM_ADDR(raddr[g]), .RAM_WDATA(rwd[g]), .RAM_WPARITY(rwp[g]),
            .RAM_RDATA(rrd[g]), .RAM_RPARITY(rrp[g]),
            .CONFLICT_CNT(cc[g])
        );

        // Behavioural RAM port: BE[0] covers low byte and parity bit 0, BE[1] the high byte and parity bit 1
        always @(posedge CLK) begin
            if (rwen[g]) begin
                if (rbe[g][0]) begin
                    mem[raddr[g]][7:0] <= rwd[g][7:0];
                    mem[raddr[g]][16]  <= rwp[g][0];
                end
                if (rbe[g][1]) begin
                    mem[raddr[g]][15:8] <= rwd[g][15:8];
                    mem[raddr[g]][17]   <= rwp[g][1];
                end
            end
            if (rren[g]) rd1 <= mem[raddr[g]];
            rd2 <= rd1;
        end

        assign rrd[g] = (RL == 2) ? rd2[15:0]  : rd1[15:0];
        assign rrp[g] = (RL == 2) ? rd2[17:16] : rd1[17:16];
    end

    // Monitor: pops the scoreboards whenever a grant or response is presented
    always @(negedge CLK) begin
        int          e;
        int          a;
        logic [20:0] er;
        logic [20:0] ar;
        for (int i = 0; i < 3; i++) begin
            if (rdy0[i] || rdy1[i]) begin
                checks++;
                a = i * 2 + (rdy1[i] ? 1 : 0);
                if (rdy0[i] && rdy1[i]) begin
                    failures++;
                    $display("FAIL grant_both inst=%0d actual=both_ready required=one_ready", i);
                end else if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected actual=inst%0d_req%0d required=no_grant", i, a % 2);
                end else begin
                    e = gq.pop_front();
                    if (a != e) begin
                        failures++;
                        $display("FAIL grant_order actual=inst%0d_req%0d required=inst%0d_req%0d",
                                 i, a % 2, e / 2, e % 2);
                    end
                end
            end
            if (rv0[i] || rv1[i]) begin
                checks++;
                ar = {2'(i), rv1[i], rdat[i]};
                if (rv0[i] && rv1[i]) begin
                    failures++;
                    $display("FAIL rsp_both inst=%0d actual=both_valid required=one_valid", i);
                end else if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected actual=%h required=no_response", ar);
                end else begin
                    er = rq.pop_front();
                    if (ar !== er) begin
                        failures++;
                        $display("FAIL rsp_data actual=%h required=%h", ar, er);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input int n, input logic we, input logic [13:0] a,
                           input logic [17:0] d, input logic [1:0] be);
        if (n == 0) begin
            v0[i] = 1'b1; we0[i] = we; a0[i] = a; wd0[i] = d; be0[i] = be;
        end else begin
            v1[i] = 1'b1; we1[i] = we; a1[i] = a; wd1[i] = d; be1[i] = be;
        end
    endtask

    // One clock: record the expected winner (g < 0 means none), then drop the requests
    task automatic step(input int i, input int g);
        if (g >= 0) gq.push_back(i * 2 + g);
        @(posedge CLK);
        #1;
        v0[i] = 1'b0;
        v1[i] = 1'b0;
    endtask

    logic [17:0] d5 [4];
    logic [1:0]  pat [7];

    initial begin
        checks   = 0;
        failures = 0;
        d5  = '{18'h1_0001, 18'h2_0002, 18'h3_0003, 18'h0_0004};
        pat = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v0[i] = 0; v1[i] = 0; we0[i] = 0; we1[i] = 0; a0[i] = 0; a1[i] = 0;
            wd0[i] = 0; wd1[i] = 0; be0[i] = 0; be1[i] = 0;
        end
        repeat (3) @(posedge CLK);
        #1;

        // Reset state: requests present during reset are neither granted nor counted
        v0[0] = 1'b1; v1[0] = 1'b1;
        @(negedge CLK);
        chk("rst_ready0", 32'(rdy0[0]), 32'd0);
        chk("rst_ready1", 32'(rdy1[0]), 32'd0);
        chk("rst_ram_strobes", 32'({rwen[0], rren[0]}), 32'd0);
        chk("rst_ram_fields", 32'({rbe[0], raddr[0], rwp[0]}), 32'd0);
        chk("rst_ram_wdata", 32'(rwd[0]), 32'd0);
        chk("rst_rsp", 32'({rv0[0], rv1[0]}), 32'd0);
        @(posedge CLK);
        #1;
        v0[0] = 1'b0; v1[0] = 1'b0;
        chk("rst_conflict", 32'(cc[0]), 32'd0);
        RESET = 1'b0;

        // Write then read the same address on the next edge; first edge out of reset accepts
        set_req(0, 0, 1'b1, 14'h0010, 18'h2_A5A5, 2'b11);
        step(0, 0);
        chk("wr_ram_wen", 32'({rwen[0], rren[0]}), 32'b10);
        chk("wr_ram_addr", 32'(raddr[0]), 32'h10);
        chk("wr_ram_wdata", 32'(rwd[0]), 32'hA5A5);
        chk("wr_ram_wpar_be", 32'({rwp[0], rbe[0]}), 32'b1011);
        set_req(0, 0, 1'b0, 14'h0010, 18'h0, 2'b00);
        rq.push_back({2'd0, 1'b0, 18'h2_A5A5});
        step(0, 0);
        chk("rd_ram_ren", 32'({rwen[0], rren[0]}), 32'b01);
        chk("rd_rsp_not_early", 32'(rv0[0]), 32'd0);
        step(0, -1);
        chk("rd_rsp_at_k1", 32'(rv0[0]), 32'd1);
        chk("idle_ram_strobes", 32'({rwen[0], rren[0]}), 32'd0);
        chk("idle_ram_addr_hold", 32'(raddr[0]), 32'h10);
        step(0, -1);
        chk("rd_rsp_one_cycle", 32'(rv0[0]), 32'd0);

        // Byte enables from requester 1: full write, then low byte only, then read back
        set_req(0, 1, 1'b1, 14'h0020, 18'h3_FFFF, 2'b11);
        step(0, 1);
        set_req(0, 1, 1'b1, 14'h0020, 18'h0_0000, 2'b01);
        step(0, 1);
        set_req(0, 1, 1'b0, 14'h0020, 18'h0, 2'b00);
        rq.push_back({2'd0, 1'b1, 18'h2_FF00});
        step(0, 1);
        step(0, -1);
        step(0, -1);

        // Round-robin contention for six cycles, back-to-back reads
        for (int c = 0; c < 6; c++) begin
            set_req(0, 0, 1'b0, 14'h0010, 18'h0, 2'b00);
            set_req(0, 1, 1'b0, 14'h0020, 18'h0, 2'b00);
            if (c % 2 == 0) rq.push_back({2'd0, 1'b0, 18'h2_A5A5});
            else            rq.push_back({2'd0, 1'b1, 18'h2_FF00});
            step(0, c % 2);
        end
        chk("rr_conflict_cnt", 32'(cc[0]), 32'd6);
        step(0, -1);
        step(0, -1);

        // Fixed priority: requester 0 wins every contended cycle
        for (int c = 0; c < 4; c++) begin
            set_req(1, 0, 1'b1, 14'(c), 18'(c), 2'b11);
            set_req(1, 1, 1'b1, 14'(100 + c), 18'(c), 2'b11);
            step(1, 0);
        end
        chk("fp_conflict_cnt", 32'(cc[1]), 32'd4);
        set_req(1, 1, 1'b1, 14'h0200, 18'h1_2345, 2'b10);
        step(1, 1);
        chk("fp_solo_req1_addr", 32'(raddr[1]), 32'h200);
        chk("fp_solo_req1_data", 32'({rwp[1], rwd[1], rbe[1]}), 32'({2'b01, 16'h2345, 2'b10}));

        // READ_LATENCY 2: preload, then alternating pipelined reads
        for (int k = 0; k < 4; k++) begin
            set_req(2, 0, 1'b1, 14'(k + 1), d5[k], 2'b11);
            step(2, 0);
        end
        for (int t = 0; t < 7; t++) begin
            if (t < 4) begin
                set_req(2, t % 2, 1'b0, 14'(t + 1), 18'h0, 2'b00);
                rq.push_back({2'd2, 1'(t % 2), d5[t]});
                step(2, t % 2);
            end else begin
                step(2, -1);
            end
            chk($sformatf("rl2_pulse_t%0d", t), 32'({rv1[2], rv0[2]}), 32'(pat[t]));
        end

        // Reset mid-read: the accepted read must never answer
        set_req(0, 0, 1'b0, 14'h0010, 18'h0, 2'b00);
        step(0, 0);
        chk("mid_rd_ren", 32'(rren[0]), 32'd1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_ren", 32'(rren[0]), 32'd0);
        chk("mid_rst_cnt", 32'(cc[0]), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int c = 0; c < 4; c++) step(0, -1);
        chk("post_rst_strobes", 32'({rwen[0], rren[0], rv0[0], rv1[0]}), 32'd0);
        chk("post_rst_fields", 32'({rbe[0], raddr[0], rwp[0]}), 32'd0);
        chk("post_rst_wdata", 32'(rwd[0]), 32'd0);
        chk("post_rst_cnt", 32'(cc[0]), 32'd0);

        // Every expected grant and response must have been seen
        checks++;
        if (gq.size() != 0) begin
            failures++;
            $display("FAIL grant_missing actual=%0d_left required=0", gq.size());
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL rsp_missing actual=%0d_left required=0", rq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdp_ram18k_port_arbiter.md
TDP_RAM18K_PORT_ARBITER -- requirements
Module: tdp_ram18k_port_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 1: RAM read latency in cycles; legal values 1 or 2.
REQ-002 Parameter FIXED_PRIORITY, default 0: 0 selects round-robin arbitration; 1 gives requester 0 absolute priority.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Ports REQ_VALID_0 / REQ_VALID_1, input, 1 bit each: requester n has a request pending.
REQ-006 Ports REQ_READY_0 / REQ_READY_1, output, 1 bit each: request n accepted this cycle.
REQ-007 Ports REQ_WE_0 / REQ_WE_1, input, 1 bit each: 1 = write, 0 = read.
REQ-008 Ports REQ_ADDR_0 / REQ_ADDR_1, input, 14 bits each: word address.
REQ-009 Ports REQ_WDATA_0 / REQ_WDATA_1, input, 18 bits each: bits [15:0] are data; bits [17:16] are parity.
REQ-010 Ports REQ_BE_0 / REQ_BE_1, input, 2 bits each: byte-write enables.
REQ-011 Ports RSP_VALID_0 / RSP_VALID_1, output, 1 bit each: read data for requester n is valid (one-cycle pulse; no backpressure).
REQ-012 Port RSP_DATA, output, 18 bits: read data, formed as {RAM_RPARITY, RAM_RDATA}, shared by both requesters.
REQ-013 Ports RAM_WEN and RAM_REN, output, 1 bit each: write enable and read enable to the RAM port.
REQ-014 Port RAM_BE, output, 2 bits: byte-write enables to the RAM port.
REQ-015 Port RAM_ADDR, output, 14 bits: address to the RAM port.
REQ-016 Port RAM_WDATA, output, 16 bits: write data to the RAM port.
REQ-017 Port RAM_WPARITY, output, 2 bits: write parity to the RAM port.
REQ-018 Port RAM_RDATA, input, 16 bits: read data from the RAM port.
REQ-019 Port RAM_RPARITY, input, 2 bits: read parity from the RAM port.
REQ-020 Port CONFLICT_CNT, output, 16 bits: count of cycles in which both requests were valid.

Function
REQ-021 The block shall accept at most one request per cycle; acceptance is REQ_VALID_n && REQ_READY_n at a rising edge.
REQ-022 REQ_READY_n shall be combinational and high only for the granted requester; a single valid requester is granted immediately.
REQ-023 Round-robin mode: when both are valid, the block shall grant the requester not granted most recently; the last-grant register resets to 1, so requester 0 wins first.
REQ-024 Fixed mode: when both are valid, the block shall always grant requester 0; the last-grant register still updates.
REQ-025 On the acceptance edge k, the RAM_* outputs shall register the granted request for one cycle.
- RAM_WEN = WE, RAM_REN = !WE.
- RAM_BE, RAM_ADDR, RAM_WDATA and RAM_WPARITY take the request fields.
- With no acceptance, RAM_WEN = RAM_REN = 0; the other RAM_* outputs hold their values.
REQ-026 For reads, a READ_LATENCY-deep tag pipeline (valid bit + requester id) shall assert RSP_VALID_id for exactly one cycle, starting at edge k+READ_LATENCY.
REQ-027 RSP_DATA shall be driven combinationally from RAM_RPARITY/RAM_RDATA; RSP_VALID_0 and RSP_VALID_1 shall never be high together.
REQ-028 Back-to-back reads shall produce back-to-back responses in acceptance order (full throughput, no bubbles).
REQ-029 Writes shall produce no response.
REQ-030 A write followed by a read to the same address on the next edge shall return the new data; the RAM port is write-first.
REQ-031 CONFLICT_CNT shall increment on every edge where REQ_VALID_0 && REQ_VALID_1, saturating at 16'hFFFF.
REQ-032 Parameter values outside their legal set shall be rejected at elaboration.

Reset
REQ-033 While RESET = 1, the block shall hold all RAM_* outputs, the tag pipeline and CONFLICT_CNT at 0, and the last-grant register at 1.
REQ-034 While RESET = 1, REQ_READY_n and RSP_VALID_n shall be 0.
REQ-035 Reset asserted mid-operation shall discard in-flight responses; no RSP_VALID shall appear after RESET deasserts for reads accepted before it.
REQ-036 The first acceptance after reset shall occur on the first rising edge with RESET low.

Verification
REQ-037 Single write then read: req0 writes 18'h2_A5A5 to addr 14'h0010 with BE = 2'b11, then reads addr 14'h0010 -> RSP_VALID_0 at acceptance edge + 1 (READ_LATENCY = 1), RSP_DATA = 18'h2_A5A5.
REQ-038 Continuous contention, round-robin: both valid for 6 cycles -> grant sequence 0,1,0,1,0,1 and CONFLICT_CNT = 6.
REQ-039 Fixed priority: FIXED_PRIORITY = 1, both valid for 4 cycles -> requester 0 granted every cycle and REQ_READY_1 stays 0.
REQ-040 Pipelined reads, READ_LATENCY = 2: alternating requesters read addrs 1,2,3,4 on consecutive edges -> four consecutive one-cycle RSP_VALID pulses routed 0,1,0,1, carrying the matching data.
REQ-041 Byte enables: write 16'hFFFF, then write 16'h0000 with BE = 2'b01, then read -> RSP_DATA[15:0] = 16'hFF00.
REQ-042 Reset mid-read: assert RESET one cycle after a read acceptance -> no RSP_VALID after release, all outputs 0, and CONFLICT_CNT = 0.
